// File: rtl/bus_arb_pkg.sv
// Shared encodings for the two-master bus arbiter: FSM states and master ids.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    M1   = 2'b01,
    M2   = 2'b10
  } arb_state_t;

  localparam logic MST1 = 1'b0;
  localparam logic MST2 = 1'b1;

  function automatic arb_state_t owner_state(input logic id);
    return (id == MST2) ? M2 : M1;
  endfunction

endpackage

// File: rtl/split_tracker.sv
// Holds the single outstanding split: owner, parked flags and the abandon timer.
module split_tracker
  import bus_arb_pkg::*;
#(
  parameter int SPLIT_TIMEOUT = 255,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic split_set,
  input  logic split_id,
  input  logic resume,
  input  logic sresume,
  output logic split_pending,
  output logic split_owner,
  output logic msplit1,
  output logic msplit2,
  output logic split_timeout
);

  localparam logic [TIMEOUT_WIDTH-1:0] LAST_COUNT = TIMEOUT_WIDTH'(SPLIT_TIMEOUT - 1);

  logic [TIMEOUT_WIDTH-1:0] count;

  // A pending sresume freezes the timer, so resume always beats an expiring split.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      split_pending <= 1'b0;
      split_owner   <= MST1;
      msplit1       <= 1'b0;
      msplit2       <= 1'b0;
      split_timeout <= 1'b0;
      count         <= '0;
    end else begin
      split_timeout <= 1'b0;
      if (resume) begin
        split_pending <= 1'b0;
        msplit1       <= 1'b0;
        msplit2       <= 1'b0;
        count         <= '0;
      end else if (split_set) begin
        split_pending <= 1'b1;
        split_owner   <= split_id;
        msplit1       <= (split_id == MST1);
        msplit2       <= (split_id == MST2);
        count         <= '0;
      end else if (split_pending && !sresume) begin
        if (count == LAST_COUNT) begin
          split_pending <= 1'b0;
          msplit1       <= 1'b0;
          msplit2       <= 1'b0;
          split_timeout <= 1'b1;
          count         <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with one outstanding split transaction.
// Optional round-robin arbitration in IDLE: define ARB_ROUND_ROBIN_EN.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int SPLIT_TIMEOUT = 255,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic breq1,
  input  logic breq2,
  input  logic ssplit,
  input  logic sresume,
  output logic bgrant1,
  output logic bgrant2,
  output logic msel,
  output logic msplit1,
  output logic msplit2,
  output logic split_grant,
  output logic split_timeout
);

  arb_state_t state;
  logic split_pending;
  logic split_owner;
  logic resume;
  logic split_set;
  logic split_id;
  logic cur_req;
  logic elig1;
  logic elig2;
  logic grant_any;
  logic grant_id;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;
`endif

  assign elig1     = breq1 & ~msplit1;
  assign elig2     = breq2 & ~msplit2;
  assign resume    = (state == IDLE) & split_pending & sresume;
  assign split_set = (state != IDLE) & ssplit & ~split_pending;
  assign split_id  = (state == M2) ? MST2 : MST1;
  assign cur_req   = (state == M2) ? breq2 : breq1;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = MST1;
    if (resume) begin
      grant_any = 1'b1;
      grant_id  = split_owner;
    end else if (elig1 && elig2) begin
      grant_any = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      grant_id  = (last_owner == MST1) ? MST2 : MST1;
`else
      grant_id  = MST1;
`endif
    end else if (elig1) begin
      grant_any = 1'b1;
      grant_id  = MST1;
    end else if (elig2) begin
      grant_any = 1'b1;
      grant_id  = MST2;
    end
  end

  // Grants are only issued from IDLE, which enforces the turnaround cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bgrant1     <= 1'b0;
      bgrant2     <= 1'b0;
      msel        <= 1'b0;
      split_grant <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner  <= MST2;
`endif
    end else begin
      split_grant <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            state       <= owner_state(grant_id);
            bgrant1     <= (grant_id == MST1);
            bgrant2     <= (grant_id == MST2);
            msel        <= grant_id;
            split_grant <= resume;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner  <= grant_id;
`endif
          end
        end
        M1, M2: begin
          if (split_set || !cur_req) begin
            state   <= IDLE;
            bgrant1 <= 1'b0;
            bgrant2 <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          bgrant1 <= 1'b0;
          bgrant2 <= 1'b0;
        end
      endcase
    end
  end

  split_tracker #(
    .SPLIT_TIMEOUT(SPLIT_TIMEOUT),
    .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
  ) u_split_tracker (
    .clk          (clk),
    .rst          (rst),
    .split_set    (split_set),
    .split_id     (split_id),
    .resume       (resume),
    .sresume      (sresume),
    .split_pending(split_pending),
    .split_owner  (split_owner),
    .msplit1      (msplit1),
    .msplit2      (msplit2),
    .split_timeout(split_timeout)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed vector bench for bus_arbiter (SPLIT_TIMEOUT=4); honours ARB_ROUND_ROBIN_EN.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic breq1, breq2, ssplit, sresume;
  logic bgrant1, bgrant2, msel, msplit1, msplit2, split_grant, split_timeout;

  int checks = 0;
  int failures = 0;

  // stim = {breq1, breq2, ssplit, sresume}
  // expected = {bgrant1, bgrant2, msel, msplit1, msplit2, split_grant, split_timeout}
  typedef struct {
    logic [3:0] stim;
    logic [6:0] expected;
  } vec_t;

  vec_t  vecs[$];
  string vec_names[$];

  bus_arbiter #(
    .SPLIT_TIMEOUT(4),
    .TIMEOUT_WIDTH(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .breq1        (breq1),
    .breq2        (breq2),
    .ssplit       (ssplit),
    .sresume      (sresume),
    .bgrant1      (bgrant1),
    .bgrant2      (bgrant2),
    .msel         (msel),
    .msplit1      (msplit1),
    .msplit2      (msplit2),
    .split_grant  (split_grant),
    .split_timeout(split_timeout)
  );

  always #5 clk = ~clk;

  task automatic addVec(input string n, input logic [3:0] s, input logic [6:0] e);
    vec_t v;
    v.stim     = s;
    v.expected = e;
    vecs.push_back(v);
    vec_names.push_back(n);
  endtask

  task automatic applyStimulus(input logic [3:0] s);
    {breq1, breq2, ssplit, sresume} = s;
  endtask

  task automatic checkOutput(input string n, input logic [6:0] e);
    logic [6:0] got;
    got = {bgrant1, bgrant2, msel, msplit1, msplit2, split_grant, split_timeout};
    checks++;
    if (got !== e) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", n, got, e);
    end
  endtask

  initial begin
    addVec("contend",         4'b1100, 7'b1000000);
    addVec("hold_m1",         4'b1100, 7'b1000000);
    addVec("m1_drop_idle",    4'b0100, 7'b0000000);
`ifdef ARB_ROUND_ROBIN_EN
    addVec("contend_again",   4'b1100, 7'b0110000);
    addVec("release_all",     4'b0000, 7'b0010000);
`else
    addVec("contend_again",   4'b1100, 7'b1000000);
    addVec("release_all",     4'b0000, 7'b0000000);
`endif
    addVec("m2_only",         4'b0100, 7'b0110000);
    addVec("m2_drop",         4'b0000, 7'b0010000);
    addVec("m1_grant",        4'b1000, 7'b1000000);
    addVec("m1_split",        4'b1010, 7'b0001000);
    addVec("parked_m2_win",   4'b1100, 7'b0111000);
    addVec("resume_wait1",    4'b1101, 7'b0111000);
    addVec("resume_wait2",    4'b1101, 7'b0111000);
    addVec("m2_release",      4'b1001, 7'b0011000);
    addVec("split_resume",    4'b1001, 7'b1000010);
    addVec("m1_after_res",    4'b1000, 7'b1000000);
    addVec("m1_release",      4'b0000, 7'b0000000);
    addVec("m1_grant_b",      4'b1000, 7'b1000000);
    addVec("m1_split_b",      4'b1010, 7'b0001000);
    addVec("m2_grant_b",      4'b1100, 7'b0111000);
    addVec("illegal_ssplit",  4'b1110, 7'b0111000);
    addVec("m2_hold_b",       4'b1100, 7'b0111000);
    addVec("timeout_busy",    4'b1100, 7'b0110001);
    addVec("m2_release_b",    4'b1000, 7'b0010000);
    addVec("m1_unparked",     4'b1000, 7'b1000000);
    addVec("m1_release_b",    4'b0000, 7'b0000000);
    addVec("m2_grant_c",      4'b0100, 7'b0110000);
    addVec("m2_split",        4'b0110, 7'b0010100);
    addVec("to_wait1",        4'b0000, 7'b0010100);
    addVec("to_wait2",        4'b0000, 7'b0010100);
    addVec("to_wait3",        4'b0000, 7'b0010100);
    addVec("timeout_pulse",   4'b0000, 7'b0010001);
    addVec("after_timeout",   4'b0000, 7'b0010000);
    addVec("m2_grant_d",      4'b0100, 7'b0110000);
    addVec("m2_split_d",      4'b0110, 7'b0010100);
    addVec("res_wait1",       4'b0000, 7'b0010100);
    addVec("res_wait2",       4'b0000, 7'b0010100);
    addVec("res_wait3",       4'b0000, 7'b0010100);
    addVec("resume_vs_to",    4'b0001, 7'b0110010);
    addVec("m2_release_d",    4'b0000, 7'b0010000);
    addVec("m1_grant_e",      4'b1000, 7'b1000000);
    addVec("split_no_req",    4'b0010, 7'b0001000);
    addVec("resume_no_req",   4'b0001, 7'b1000010);
    addVec("m1_release_e",    4'b0000, 7'b0000000);

    rst = 1'b1;
    applyStimulus(4'b0000);
    #1;
    checkOutput("reset_state", 7'b0000000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].stim);
      @(posedge clk);
      #1;
      checkOutput(vec_names[i], vecs[i].expected);
    end

    // Asynchronous reset in the middle of an owned cycle.
    applyStimulus(4'b1000);
    @(posedge clk);
    #1;
    checkOutput("pre_rst_grant", 7'b1000000);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst", 7'b0000000);
    applyStimulus(4'b0100);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_m2", 7'b0110000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
